// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack bus master with lane formatting.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W instead of aligning.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic [4:0]  o_ld_rd_addr,
  output logic        o_bus_err,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);

  state_t state, state_nxt;

  logic [31:0] addr_q, wd_q, ld_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q, ld_rd_q;
  logic        we_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_b, is_h;
  logic        accept, go, tmo;
  logic [31:0] eff_addr;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt, ld_fmt;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign is_b   = i_funct3[1:0] == 2'b00;
  assign is_h   = i_funct3[1:0] == 2'b01;
  assign accept = (state == IDLE) && i_valid
                  && (i_mem_rd || i_mem_wr);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis = (is_h && i_addr[0])
             || (!is_b && !is_h && (i_addr[1:0] != 2'b00));
  assign go         = accept && !mis;
  assign o_misalign = accept && mis;
  assign eff_addr   = i_addr;
`else
  assign go         = accept;
  assign o_misalign = 1'b0;
  assign eff_addr   = {i_addr[31:2],
                       is_b ? i_addr[1:0] :
                       is_h ? {i_addr[1], 1'b0} : 2'b00};
`endif

  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = i_wdata;
    unique case (1'b1)
      is_b: begin
        be_nxt = 4'b0001 << eff_addr[1:0];
        wd_nxt = {4{i_wdata[7:0]}};
      end
      is_h: begin
        be_nxt = eff_addr[1] ? 4'b1100 : 4'b0011;
        wd_nxt = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lb = i_bus_rdata[8*addr_q[1:0] +: 8];
  assign lh = addr_q[1] ? i_bus_rdata[31:16]
                        : i_bus_rdata[15:0];

  always_comb begin
    ld_fmt = i_bus_rdata;
    unique case (1'b1)
      f3_q[1:0] == 2'b00:
        ld_fmt = f3_q[2] ? {24'b0, lb}
                         : {{24{lb[7]}}, lb};
      f3_q[1:0] == 2'b01:
        ld_fmt = f3_q[2] ? {16'b0, lh}
                         : {{16{lh[15]}}, lh};
      default: ;
    endcase
  end

  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == TO);

  always_comb begin
    state_nxt  = state;
    o_stall    = 1'b0;
    o_bus_req  = 1'b0;
    o_bus_err  = 1'b0;
    o_ld_valid = 1'b0;
    unique case (state)
      IDLE: if (go) begin
        o_stall   = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        o_stall = 1'b1;
        if (tmo) begin
          o_bus_err = 1'b1;
          state_nxt = DONE;
        end else begin
          o_bus_req = 1'b1;
          if (i_bus_ack) state_nxt = DONE;
        end
      end
      DONE: begin
        o_ld_valid = !we_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
      ld_rd_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        addr_q <= eff_addr;
        wd_q   <= wd_nxt;
        be_q   <= be_nxt;
        f3_q   <= i_funct3;
        rd_q   <= i_rd_addr;
        we_q   <= i_mem_wr;
        cnt_q  <= '0;
      end
      if (state == REQ) begin
        if (tmo || i_bus_ack) begin
          if (!we_q) begin
            ld_q    <= tmo ? 32'h0 : ld_fmt;
            ld_rd_q <= rd_q;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign o_bus_we     = we_q;
  assign o_bus_addr   = {addr_q[31:2], 2'b00};
  assign o_bus_be     = be_q;
  assign o_bus_wdata  = wd_q;
  assign o_ld_data    = ld_q;
  assign o_ld_rd_addr = ld_rd_q;

endmodule
